hamming_enc: RTL and testbench

Streaming Hamming(7,4) encoder on the transmit side of the team's Hamming link. It accepts 4-bit data nibbles over a valid/ready handshake and produces 7-bit codewords through a 2-entry output buffer. Every codeword has a zero syndrome under the single-error-correcting decoder used on the receive side. Optionally, it can inject a single-bit error per word so the decoder's correction path can be exercised end to end.

---
 rtl/hamming_enc_if.sv | 24 ++
 rtl/hamming_enc.sv | 109 ++++++++++
 tb/tb_hamming_enc.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_enc_if.sv
// hamming_enc_if: stream signals of the Hamming(7,4) transmit link.
//   master - upstream/downstream environment: drives data_in, in_valid, err_en,
//            err_pos, out_ready; observes in_ready, code_out, out_valid.
//   slave  - the encoder: consumes the nibble stream and produces codewords.
interface hamming_enc_if;
    logic [3:0] data_in;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] code_out;
    logic       out_valid;
    logic       out_ready;
    logic       err_en;
    logic [2:0] err_pos;

    modport master (
        output data_in, in_valid, out_ready, err_en, err_pos,
        input  in_ready, code_out, out_valid
    );

    modport slave (
        input  data_in, in_valid, out_ready, err_en, err_pos,
        output in_ready, code_out, out_valid
    );
endinterface

// File: rtl/hamming_enc.sv
// hamming_enc: streaming Hamming(7,4) encoder with a 2-entry output buffer.
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset; discards buffered words
//   link     - hamming_enc_if.slave: data_in/in_valid/in_ready nibble input,
//              code_out/out_valid/out_ready codeword output, err_en/err_pos
//   word_cnt - count of codewords transferred on the output side (wraps)
// Optional feature: define HAMMING_ENC_ERRINJ_EN to enable single-bit error
// injection on accepted words; otherwise err_en/err_pos are ignored.
module hamming_enc #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    hamming_enc_if.slave     link,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e           state_q;
    logic [6:0]       e0_q, e1_q;
    logic             in_ready_q, out_valid_q;
    logic [CNT_W-1:0] word_cnt_q;

    logic             push, pop;
    logic [6:0]       clean_word, wr_word;

    // c[6:4] are the parity bits; c[3:0] carries the nibble unchanged.
    function automatic logic [6:0] encode(input logic [3:0] d);
        return {d[3] ^ d[1] ^ d[0], d[3] ^ d[2] ^ d[1], d[2] ^ d[1] ^ d[0], d};
    endfunction

    assign clean_word = encode(link.data_in);

`ifdef HAMMING_ENC_ERRINJ_EN
    logic [6:0] flip_mask;
    always_comb begin
        flip_mask = '0;
        if (link.err_en && (link.err_pos != 3'd7)) begin
            flip_mask[link.err_pos] = 1'b1;
        end
    end
    assign wr_word = clean_word ^ flip_mask;
`else
    logic unused_err;
    assign unused_err = ^{link.err_en, link.err_pos};
    assign wr_word    = clean_word;
`endif

    assign push = link.in_valid & in_ready_q;
    assign pop  = out_valid_q & link.out_ready;

    // in_ready/out_valid are registered from the next state so in_ready never
    // depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            e0_q        <= '0;
            e1_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            if (pop) begin
                word_cnt_q <= word_cnt_q + 1'b1;
            end
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        e0_q        <= wr_word;
                        state_q     <= StOne;
                        out_valid_q <= 1'b1;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        // Head leaves as the new word arrives; it becomes the head.
                        e0_q <= wr_word;
                    end else if (push) begin
                        e1_q       <= wr_word;
                        state_q    <= StFull;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        state_q     <= StEmpty;
                        out_valid_q <= 1'b0;
                    end
                end
                StFull: begin
                    if (pop) begin
                        e0_q       <= e1_q;
                        state_q    <= StOne;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StEmpty;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign link.in_ready  = in_ready_q;
    assign link.out_valid = out_valid_q;
    assign link.code_out  = e0_q;
    assign word_cnt       = word_cnt_q;

endmodule

// File: tb/tb_hamming_enc.sv
// tb_hamming_enc: directed test of hamming_enc against a queue-based model.
module tb_hamming_enc;

    logic        clk;
    logic        rst;
    logic [15:0] word_cnt;

    hamming_enc_if link ();

    hamming_enc #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .link     (link),
        .word_cnt (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Syndrome from the decoder's parity-check equations.
    function automatic logic [2:0] syndrome(input logic [6:0] c);
        return {c[6] ^ c[3] ^ c[1] ^ c[0], c[5] ^ c[3] ^ c[2] ^ c[1], c[4] ^ c[2] ^ c[1] ^ c[0]};
    endfunction

    // The codeword is the unique 7-bit word carrying d in c[3:0] with zero syndrome.
    function automatic logic [6:0] model_enc(input logic [3:0] d);
        logic [6:0] c;
        for (int v = 0; v < 128; v++) begin
            c = v[6:0];
            if (c[3:0] == d && syndrome(c) == 3'b000) return c;
        end
        return 7'h00;
    endfunction

    // Single-error correction by searching for the one flip that clears the syndrome.
    function automatic logic [6:0] model_dec(input logic [6:0] c);
        logic [6:0] t;
        if (syndrome(c) == 3'b000) return c;
        for (int i = 0; i < 7; i++) begin
            t = c ^ (7'd1 << i);
            if (syndrome(t) == 3'b000) return t;
        end
        return c;
    endfunction

    // Reference model: queue of codewords plus transfer counter.
    logic [6:0]  mq[$];
    logic [15:0] mcnt;

    always @(posedge clk) begin
        int         sz;
        bit         do_push, do_pop;
        logic [6:0] w;
        if (rst) begin
            mq.delete();
            mcnt = '0;
        end else begin
            sz      = mq.size();
            do_push = link.in_valid && (sz != 2);
            do_pop  = link.out_ready && (sz != 0);
            w       = model_enc(link.data_in);
`ifdef HAMMING_ENC_ERRINJ_EN
            if (link.err_en && link.err_pos != 3'd7) w = w ^ (7'd1 << link.err_pos);
`endif
            if (do_pop) begin
                void'(mq.pop_front());
                mcnt = mcnt + 16'd1;
            end
            if (do_push) mq.push_back(w);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (started && !rst) begin
            check("m_in_ready", link.in_ready, mq.size() != 2);
            check("m_out_valid", link.out_valid, mq.size() != 0);
            check("m_word_cnt", word_cnt, mcnt);
            if (mq.size() != 0) check("m_code_out", link.code_out, mq[0]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    logic [6:0] exp_err;

    initial begin
        rst            = 1'b1;
        link.data_in   = '0;
        link.in_valid  = 1'b0;
        link.out_ready = 1'b0;
        link.err_en    = 1'b0;
        link.err_pos   = 3'd7;

        // Reset state and single-word latency.
        do_reset();
        started = 1'b1;
        check("rst_in_ready", link.in_ready, 1);
        check("rst_out_valid", link.out_valid, 0);
        check("rst_code_out", link.code_out, 7'h00);
        check("rst_word_cnt", word_cnt, 0);
        link.data_in   = 4'hB;
        link.in_valid  = 1'b1;
        link.out_ready = 1'b1;
        cyc();
        link.in_valid = 1'b0;
        check("lat_valid", link.out_valid, 1);
        check("lat_code_B", link.code_out, 7'h4B);
        cyc();
        check("lat_word_cnt", word_cnt, 1);
        check("lat_empty", link.out_valid, 0);

        // Exhaustive sweep at full throughput.
        do_reset();
        link.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            link.data_in  = i[3:0];
            link.in_valid = 1'b1;
            cyc();
            check("sweep_valid", link.out_valid, 1);
            check("sweep_syndrome", syndrome(link.code_out), 0);
            if (i == 0)  check("sweep_code_0", link.code_out, 7'h00);
            if (i == 1)  check("sweep_code_1", link.code_out, 7'h51);
            if (i == 15) check("sweep_code_F", link.code_out, 7'h7F);
        end
        link.in_valid = 1'b0;
        cyc();
        check("sweep_word_cnt", word_cnt, 16);

        // Back-pressure: fill, then drain in order.
        do_reset();
        link.out_ready = 1'b0;
        link.data_in   = 4'h1;
        link.in_valid  = 1'b1;
        cyc();
        check("bp_ready_one", link.in_ready, 1);
        link.data_in = 4'hF;
        cyc();
        link.in_valid = 1'b0;
        check("bp_ready_full", link.in_ready, 0);
        check("bp_head_1", link.code_out, 7'h51);
        link.out_ready = 1'b1;
        cyc();
        check("bp_head_F", link.code_out, 7'h7F);
        check("bp_ready_back", link.in_ready, 1);
        cyc();
        check("bp_drained", link.out_valid, 0);
        check("bp_word_cnt", word_cnt, 2);

        // Simultaneous push and pop while holding one word.
        do_reset();
        link.out_ready = 1'b0;
        link.data_in   = 4'h3;
        link.in_valid  = 1'b1;
        cyc();
        link.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            link.data_in = 4'(k + 4);
            cyc();
            check("pp_ready", link.in_ready, 1);
            check("pp_valid", link.out_valid, 1);
        end
        link.in_valid = 1'b0;
        cyc();
        check("pp_word_cnt", word_cnt, 11);
        check("pp_empty", link.out_valid, 0);

        // Error injection.
        do_reset();
        link.out_ready = 1'b0;
        link.data_in   = 4'hB;
        link.in_valid  = 1'b1;
        link.err_en    = 1'b1;
        link.err_pos   = 3'd6;
        cyc();
        link.in_valid = 1'b0;
`ifdef HAMMING_ENC_ERRINJ_EN
        exp_err = 7'h0B;
`else
        exp_err = 7'h4B;
`endif
        check("inj_pos6", link.code_out, exp_err);
        check("inj_decoded", model_dec(link.code_out), 7'h4B);
        link.out_ready = 1'b1;
        link.err_pos   = 3'd7;
        link.in_valid  = 1'b1;
        cyc();
        link.in_valid = 1'b0;
        link.err_en   = 1'b0;
        check("inj_pos7", link.code_out, 7'h4B);
        cyc();

        // Reset while full discards buffered words.
        link.out_ready = 1'b0;
        link.data_in   = 4'h2;
        link.in_valid  = 1'b1;
        cyc();
        cyc();
        link.in_valid = 1'b0;
        check("rf_full", link.in_ready, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rf_out_valid", link.out_valid, 0);
        check("rf_in_ready", link.in_ready, 1);
        check("rf_word_cnt", word_cnt, 0);
        link.data_in   = 4'h5;
        link.in_valid  = 1'b1;
        link.out_ready = 1'b1;
        cyc();
        link.in_valid = 1'b0;
        check("rf_code_5", link.code_out, 7'h65);
        cyc();
        check("rf_word_cnt_after", word_cnt, 1);

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
